// File: rtl/eth_tx_frame_arb.sv
// Round-robin merge of CHANNELS AXI-Stream TX sources into one frame stream toward the MAC.
// Whole frames only, one idle cycle between frames; short frames zero-padded to MIN_FRAME_LENGTH beats.
module eth_tx_frame_arb #(
  parameter int CHANNELS         = 4,
  parameter int DATA_WIDTH       = 8,
  parameter int ENABLE_PADDING   = 1,
  parameter int MIN_FRAME_LENGTH = 8,
  localparam int TID_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int CNT_W = $clog2(MIN_FRAME_LENGTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]            s_axis_tvalid,
  input  logic [CHANNELS-1:0]            s_axis_tlast,
  input  logic [CHANNELS-1:0]            s_axis_tuser,
  output logic [CHANNELS-1:0]            s_axis_tready,
  output logic [DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                           m_axis_tvalid,
  output logic                           m_axis_tlast,
  output logic                           m_axis_tuser,
  input  logic                           m_axis_tready,
  output logic [TID_W-1:0]               m_axis_tid,
  output logic                           busy,
  output logic                           frame_done,
  output logic [TID_W-1:0]               frame_done_ch,
  output logic                           frame_padded
);

  typedef enum logic [1:0] {IDLE, PASS, PAD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MIN_FRAME_LENGTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MIN_FRAME_LENGTH - 1);

  state_t                 state, state_nxt;
  logic [TID_W-1:0]       grant, last_grant, arb_sel;
  logic                   arb_found;
  logic [CNT_W-1:0]       count;
  logic                   tuser_lat;
  logic [DATA_WIDTH-1:0]  sel_dat;
  logic                   sel_vld, sel_last, sel_user;
  logic [CHANNELS-1:0]    gnt_oh;
  logic                   short_frame, pad_last, done_now, hs;
  int                     idx;

  // Rotating priority: first requester above last_grant, wrapping.
  always_comb begin
    arb_sel   = '0;
    arb_found = 1'b0;
    idx       = 0;
    for (int k = 1; k <= CHANNELS; k++) begin
      idx = (int'(last_grant) + k) % CHANNELS;
      if (!arb_found && s_axis_tvalid[idx]) begin
        arb_found = 1'b1;
        arb_sel   = TID_W'(idx);
      end
    end
  end

  always_comb begin
    sel_dat  = '0;
    sel_vld  = 1'b0;
    sel_last = 1'b0;
    sel_user = 1'b0;
    gnt_oh   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (int'(grant) == i) begin
        gnt_oh[i] = 1'b1;
        sel_dat   = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_vld   = s_axis_tvalid[i];
        sel_last  = s_axis_tlast[i];
        sel_user  = s_axis_tuser[i];
      end
    end
  end

  assign short_frame = (ENABLE_PADDING != 0) && ((int'(count) + 1) < MIN_FRAME_LENGTH);
  assign pad_last    = (count == CNT_LAST);
  assign hs          = m_axis_tvalid && m_axis_tready;

  always_comb begin
    state_nxt     = state;
    s_axis_tready = '0;
    m_axis_tdata  = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    done_now      = 1'b0;
    case (state)
      IDLE: begin
        if (arb_found) state_nxt = PASS;
      end
      PASS: begin
        s_axis_tready = gnt_oh & {CHANNELS{m_axis_tready}};
        m_axis_tdata  = sel_dat;
        m_axis_tvalid = sel_vld;
        // A short frame's real last beat is hidden; the pad tail carries tlast/tuser.
        m_axis_tlast  = sel_last && !short_frame;
        m_axis_tuser  = sel_user && !(sel_last && short_frame);
        if (sel_vld && m_axis_tready && sel_last) begin
          if (short_frame) begin
            state_nxt = PAD;
          end else begin
            state_nxt = IDLE;
            done_now  = 1'b1;
          end
        end
      end
      PAD: begin
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = pad_last;
        m_axis_tuser  = pad_last && tuser_lat;
        if (m_axis_tready && pad_last) begin
          state_nxt = IDLE;
          done_now  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      grant         <= '0;
      last_grant    <= TID_W'(CHANNELS - 1);
      count         <= '0;
      tuser_lat     <= 1'b0;
      frame_done    <= 1'b0;
      frame_done_ch <= '0;
      frame_padded  <= 1'b0;
    end else begin
      state        <= state_nxt;
      frame_done   <= done_now;
      frame_padded <= done_now && (state == PAD);
      if (done_now) begin
        frame_done_ch <= grant;
        last_grant    <= grant;
      end
      case (state)
        IDLE: begin
          if (arb_found) begin
            grant <= arb_sel;
            count <= '0;
          end
        end
        PASS, PAD: begin
          if (hs && count != CNT_MAX) count <= count + CNT_W'(1);
          if (state == PASS && hs && sel_last && short_frame) tuser_lat <= sel_user;
        end
        default: ;
      endcase
    end
  end

  assign m_axis_tid = grant;
  assign busy       = (state != IDLE);

endmodule

// File: doc/eth_tx_frame_arb.md
ETH_TX_FRAME_ARB -- requirements
Module: eth_tx_frame_arb

Interface
REQ-001 The block SHALL have parameter CHANNELS, default 4, number of AXI-Stream TX sources (legal 1..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8, bits per beat (one byte per beat at 8).
REQ-003 The block SHALL have parameter ENABLE_PADDING, default 1, to enable zero-padding of short frames.
REQ-004 The block SHALL have parameter MIN_FRAME_LENGTH, default 8, minimum beats per output frame when padding is enabled (legal 1..1023).
REQ-005 The block SHALL have port clk, input, 1, the single clock for all logic.
REQ-006 The block SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 The block SHALL have ports s_axis_tdata, input, CHANNELS*DATA_WIDTH, per-channel data, with channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-008 The block SHALL have ports s_axis_tvalid, s_axis_tlast and s_axis_tuser, inputs, CHANNELS each, per-channel valid, frame end and error flag.
REQ-009 The block SHALL have port s_axis_tready, output, CHANNELS, per-channel ready.
REQ-010 The block SHALL have ports m_axis_tdata (DATA_WIDTH) and m_axis_tvalid, m_axis_tlast, m_axis_tuser (1 each), outputs, the merged stream toward the MAC TX FIFO.
REQ-011 The block SHALL have port m_axis_tready, input, 1, downstream ready.
REQ-012 The block SHALL have port m_axis_tid, output, max(1,$clog2(CHANNELS)), index of the channel owning the current frame.
REQ-013 The block SHALL have port busy, output, 1, high in PASS or PAD.
REQ-014 The block SHALL have port frame_done, output, 1, one-cycle pulse per completed output frame.
REQ-015 The block SHALL have ports frame_done_ch (width of m_axis_tid) and frame_padded (1), outputs, the source channel and padded flag qualified by frame_done.

Function
REQ-016 The block SHALL implement FSM states IDLE, PASS and PAD.
REQ-017 In IDLE, when any s_axis_tvalid is high, the block SHALL register grant to the first requesting channel searching upward, with wrap, from last_grant+1, and SHALL enter PASS on the next cycle.
REQ-018 In IDLE, all s_axis_tready and m_axis_tvalid SHALL be 0, giving one bubble cycle between frames.
REQ-019 In PASS, m_axis_tdata, m_axis_tvalid and m_axis_tuser SHALL combinationally follow the granted channel.
REQ-020 In PASS, s_axis_tready[grant] SHALL equal m_axis_tready, and all other s_axis_tready SHALL be 0.
REQ-021 Grant SHALL be held until the frame completes; other channels SHALL NOT interleave mid-frame.
REQ-022 A beat counter SHALL clear on entry to PASS and SHALL increment on each output handshake; it SHALL be $clog2(MIN_FRAME_LENGTH+1) bits and SHALL saturate at MIN_FRAME_LENGTH.
REQ-023 On a handshake of the granted tlast beat in PASS with ENABLE_PADDING=1 and count+1 < MIN_FRAME_LENGTH, the block SHALL drive m_axis_tlast=0 and m_axis_tuser=0 on that beat, latch the input tuser, and enter PAD.
REQ-024 On a handshake of the granted tlast beat in PASS otherwise, m_axis_tlast and m_axis_tuser SHALL pass through and the block SHALL enter IDLE.
REQ-025 In PAD, the block SHALL drive m_axis_tdata=0 and m_axis_tvalid=1 with all s_axis_tready at 0.
REQ-026 In PAD, m_axis_tlast SHALL be 1 only when count==MIN_FRAME_LENGTH-1, and m_axis_tuser SHALL carry the latched tuser on that beat only.
REQ-027 On the final PAD handshake, the block SHALL enter IDLE.
REQ-028 m_axis_tvalid SHALL NOT drop, and m_axis_tdata SHALL NOT change, while m_axis_tvalid=1 and m_axis_tready=0, provided the source obeys AXI-Stream.
REQ-029 last_grant SHALL update to grant on frame completion.
REQ-030 frame_done SHALL pulse the cycle after the final output handshake, with frame_done_ch=grant and frame_padded=1 if the frame passed through PAD.
REQ-031 With CHANNELS=1, arbitration SHALL reduce to always granting channel 0.
REQ-032 A frame whose own length is ≥ MIN_FRAME_LENGTH, or any frame when ENABLE_PADDING=0, SHALL pass unmodified.

Reset
REQ-033 While rst_n=0 at a clk edge, the block SHALL set the state to IDLE, grant and m_axis_tid to 0, last_grant to CHANNELS-1 (channel 0 has first priority), the counter to 0, and the latched tuser to 0.
REQ-034 In reset, all s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, frame_done and frame_padded SHALL be 0.
REQ-035 Reset asserted mid-frame SHALL abandon the frame without emitting tlast or frame_done; the downstream FIFO handles the truncation.

Verification
REQ-036 The bench SHALL cover: CHANNELS=4, all four channels valid with 10-beat frames, m_axis_tready=1 -> output frames in order ch0,1,2,3,0, each 10 beats, one idle cycle between frames, frame_padded=0.
REQ-037 The bench SHALL cover: MIN_FRAME_LENGTH=8, ch2 sends 3 beats A,B,C with tuser=1 on last -> output A,B,C,0,0,0,0,0 with tlast and tuser=1 on beat 8 only, m_axis_tid=2, frame_padded=1.
REQ-038 The bench SHALL cover: ENABLE_PADDING=0, 1-beat frame -> 1-beat output with tlast=1, frame_done one cycle later.
REQ-039 The bench SHALL cover: random m_axis_tready backpressure, 20% duty, during PASS and PAD -> tdata/tvalid stable while stalled, no beat lost or duplicated, beat count exact.
REQ-040 The bench SHALL cover: ch1 requesting mid-frame of ch0 -> ch1 granted only after ch0's tlast handshake plus one idle cycle.
REQ-041 The bench SHALL cover: rst_n=0 for one cycle at beat 5 of a 10-beat frame -> next cycle all outputs 0, state IDLE, and the next grant goes to channel 0 if requesting.
